tb_memory_port_arbiter: RTL

//  Shares one testbench memory-model access port between REQUESTERS agents.

---
 rtl/pztb_pkg.sv | 17 +
 rtl/tb_memory_id_fifo.sv | 57 +++++
 rtl/tb_memory_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pztb_pkg.sv
// Shared types and helpers for the pztb memory-model access path.
// pztb_mem_command : command kind used by bus-agent BFMs and the arbiter stage.
// rr_index         : wrap-around index used by the round-robin search.
package pztb_pkg;

  typedef enum logic {
    PZTB_MEM_READ  = 1'b0,
    PZTB_MEM_WRITE = 1'b1
  } pztb_mem_command;

  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned offset,
                                           input int unsigned n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/tb_memory_id_fifo.sv
// Synchronous FIFO holding requester IDs of reads granted but not yet returned.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset (to empty)
//   push, push_data    enqueue an ID (ignored when full and not popping)
//   pop, pop_data      dequeue the head ID (ignored when empty)
//   empty, full        occupancy flags
module tb_memory_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tb_memory_port_arbiter.sv
// Shares one memory-model access port between REQUESTERS agents.
// Round-robin grant into a registered command stage, outstanding-read tracking,
// and in-order routing of read data back to the issuing agent.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_req_valid/write/address/data/mask   per-agent request (flattened vectors)
//   o_req_ready                       per-agent accept, one-hot or zero
//   o_mem_valid/write/address/data/mask, i_mem_ready   command to memory
//   i_mem_rvalid, i_mem_rdata         in-order read return
//   o_resp_valid, o_resp_data         one-hot registered read response
module tb_memory_port_arbiter
  import pztb_pkg::*;
#(
  parameter int unsigned REQUESTERS      = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDRESS_WIDTH   = 10,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [REQUESTERS-1:0]               i_req_valid,
  output logic [REQUESTERS-1:0]               o_req_ready,
  input  logic [REQUESTERS-1:0]               i_req_write,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]    i_req_data,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]    i_req_mask,
  output logic                                o_mem_valid,
  input  logic                                i_mem_ready,
  output logic                                o_mem_write,
  output logic [ADDRESS_WIDTH-1:0]            o_mem_address,
  output logic [DATA_WIDTH-1:0]               o_mem_data,
  output logic [DATA_WIDTH-1:0]               o_mem_mask,
  input  logic                                i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]               i_mem_rdata,
  output logic [REQUESTERS-1:0]               o_resp_valid,
  output logic [DATA_WIDTH-1:0]               o_resp_data
);

  localparam int unsigned ID_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   sel;
  logic [ID_WIDTH-1:0]   pop_id;
  logic [CNT_W-1:0]      count;
  logic [REQUESTERS-1:0] eligible;
  logic                  found;
  logic                  grant;
  logic                  grant_read;
  logic                  rd_pop;
  logic                  stage_free;
  logic                  reads_open;
  logic                  fifo_empty;
  logic                  fifo_full;
  int unsigned           idx;
  pztb_mem_command       stage_cmd;

  assign stage_free = ~o_mem_valid | i_mem_ready;
  assign reads_open = (count < CNT_W'(MAX_OUTSTANDING)) & ~fifo_full;
  assign rd_pop     = i_mem_rvalid & ~fifo_empty;
  assign o_mem_write = (stage_cmd == PZTB_MEM_WRITE);

  // Search starts at the pointer and wraps; the first eligible agent wins.
  always_comb begin
    eligible    = '0;
    found       = 1'b0;
    sel         = '0;
    idx         = 0;
    o_req_ready = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      eligible[i] = i_req_valid[i] & (i_req_write[i] | reads_open);
    end
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      idx = rr_index(32'(rr_ptr), k, REQUESTERS);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = ID_WIDTH'(idx);
      end
    end
    grant      = found & stage_free;
    grant_read = grant & ~i_req_write[sel];
    if (grant) o_req_ready[sel] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_valid   <= 1'b0;
      stage_cmd     <= PZTB_MEM_READ;
      o_mem_address <= '0;
      o_mem_data    <= '0;
      o_mem_mask    <= '0;
      rr_ptr        <= '0;
    end else if (grant) begin
      o_mem_valid   <= 1'b1;
      stage_cmd     <= i_req_write[sel] ? PZTB_MEM_WRITE : PZTB_MEM_READ;
      o_mem_address <= i_req_address[32'(sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      o_mem_data    <= i_req_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
      o_mem_mask    <= i_req_mask[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
      rr_ptr        <= (sel == ID_WIDTH'(REQUESTERS - 1)) ? '0 : sel + ID_WIDTH'(1);
    end else if (i_mem_ready) begin
      o_mem_valid   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else begin
      case ({grant_read, rd_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_resp_valid <= '0;
      o_resp_data  <= '0;
    end else begin
      o_resp_valid <= '0;
      if (rd_pop) begin
        o_resp_valid[pop_id] <= 1'b1;
        o_resp_data          <= i_mem_rdata;
      end
    end
  end

  tb_memory_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_WIDTH)
  ) u_id_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (grant_read),
    .push_data (sel),
    .pop       (rd_pop),
    .pop_data  (pop_id),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Read data arriving with nothing outstanding is dropped.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_mem_rvalid && fifo_empty))
    else $error("tb_memory_port_arbiter: read data returned with no outstanding read");

endmodule
